free_list: RTL and testbench
============================

Name: free_list

Overview:
- Physical-register free list for the R10K-style rename path.
- Consumer end of the retire interface: accepts per-lane Told returns (FL_RetireEN/FL_RetireReg) and supplies up to N free physical registers per cycle to dispatch/rename.
- On branch recovery (BPRecoverEN) it discards its contents and runs a multi-cycle rebuild. The rebuild scans the precise arch map image and refills the list with every physical register the arch map does not reference.

Parameters:
- N, `N, superscalar width (alloc and retire lanes).
- ARCH_COUNT, 32, architectural registers.
- PHYS_REGS, `PHYS_REG_SZ_R10K, physical registers.
- PRW, localparam, $clog2(PHYS_REGS), physical tag width.
- DEPTH, localparam, PHYS_REGS-ARCH_COUNT, list capacity.
- CW, localparam, $clog2(DEPTH+1), count width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- alloc_req  in  N  rename lane wants a dest tag; lane N-1 oldest
- alloc_reg  out  N x PRW  tag granted to each requesting lane
- alloc_stall  out  1  requests not honoured this cycle
- free_count  out  CW  entries currently in list
- FL_RetireEN  in  N  return prev_phys_rd of lane
- FL_RetireReg  in  N x PRW  Told tag per lane
- BPRecoverEN  in  1  recovery pulse from retire
- archi_maptable  in  ARCH_COUNT x PRW  precise map image
- rebuild_busy  out  1  rebuild in progress

Behaviour:
- Storage: circular array of DEPTH tags, head/tail pointers wrapping modulo DEPTH, registered count.
- Reset (async):
  - entries[i] = ARCH_COUNT+i; head=0, tail=0 (full), count=DEPTH.
  - state=IDLE; rebuild_busy=0; alloc_stall=0; alloc_reg=0.
- Allocation (IDLE only):
  - k = popcount(alloc_req).
  - If k <= count: requesting lanes take consecutive entries from head, oldest lane (N-1) first. alloc_reg is combinational from current array contents. head += k, count -= k at the clock edge.
  - If k > count or state != IDLE: all-or-nothing, no pop, alloc_stall=1.
  - Non-requesting lanes drive alloc_reg=0.
- Return:
  - Each enabled FL_RetireEN lane writes at tail, compacted oldest lane first; tail += popcount, count += popcount.
  - Returned tags become allocatable the next cycle, never same-cycle bypass.
  - Same-cycle push and pop are both applied; new count = count - k + pushes.
  - A push that would exceed DEPTH, or any push of tag 0, fires an assertion. No pointer update beyond DEPTH.
- Recovery (BPRecoverEN=1, any state):
  - Dominates. Allocation and returns in that cycle are ignored; alloc_stall=1.
  - Next edge: head=tail=count=0. Snapshot in_use[PHYS_REGS] is set from archi_maptable (bit set for each mapped tag). scan_ptr=0, state=REBUILD.
- REBUILD state:
  - Each cycle, examine tags scan_ptr..scan_ptr+N-1 (clipped at PHYS_REGS). Push those with in_use=0, ascending order; scan_ptr += N.
  - When scan_ptr+N >= PHYS_REGS, the final group is pushed and state returns to IDLE.
  - Duration ceil(PHYS_REGS/N) cycles. rebuild_busy=1 and alloc_stall=1 throughout.
  - Returns during REBUILD are ignored and assert (ROB is flushed).
  - BPRecoverEN during REBUILD restarts from a fresh snapshot.
- After rebuild, count = PHYS_REGS - popcount(distinct tags in archi_maptable), which equals DEPTH for an injective map.
- Reset mid-rebuild returns to the reset image.

Decomposition:
- Shared package holds DEPTH, CW, and a PHYS_TAG typedef (logic [PRW-1:0]), so rename, ROB and retire share tag width.
- One natural sub-module, free_list_compact: an N-lane valid-mask to prefix-offset compactor. It is used for alloc, return and rebuild-push lane packing.

Test Plan:
- Reset, N=2, PHYS=64: free_count=32; alloc_req=2'b11 -> alloc_reg[1]=32, alloc_reg[0]=33; next cycle free_count=30.
- count=1, alloc_req=2'b11 -> alloc_stall=1, no pop, free_count stays 1. Then alloc_req=2'b10 -> alloc_reg[1]=head tag, count=0.
- Same cycle: pop 2, return tags 40,41 at count=5 -> count=5. Tags 40,41 are granted only after all 5 older entries are drained, proving FIFO order and wrap at DEPTH=32.
- BPRecoverEN with arch map r0..r31 -> P0,P33..P63: rebuild_busy high 32 cycles, stall asserted. Final list = P1..P32 ascending, free_count=32.
- BPRecoverEN asserted again at rebuild cycle 10 with a different map: scan restarts, list reflects only the second snapshot.
- Assert reset at rebuild cycle 5 -> immediate reset image: count=32, head tag 32, rebuild_busy=0.

Source files
------------

// File: rtl/free_list_pkg.sv
// free_list_pkg: definitions shared by the rename, ROB and retire blocks.
//   FL_*     default machine shape: width, architectural and physical registers
//   FL_DEPTH free-list capacity (physical minus architectural registers)
//   FL_CW    width of an occupancy count 0..FL_DEPTH
//   PHYS_TAG physical register tag type
//   fl_state_e free-list controller state
package free_list_pkg;

  localparam int FL_N          = 2;
  localparam int FL_ARCH_COUNT = 32;
  localparam int FL_PHYS_REGS  = 64;
  localparam int FL_PRW        = $clog2(FL_PHYS_REGS);
  localparam int FL_DEPTH      = FL_PHYS_REGS - FL_ARCH_COUNT;
  localparam int FL_CW         = $clog2(FL_DEPTH + 1);

  typedef logic [FL_PRW-1:0] PHYS_TAG;

  typedef enum logic {
    IDLE    = 1'b0,
    REBUILD = 1'b1
  } fl_state_e;

endpackage

// File: rtl/free_list_compact.sv
// free_list_compact: turns an N-lane valid mask into packing offsets.
// Lane N-1 is the oldest, so it is packed first: a lane's offset is the number
// of valid lanes above it.
//   valid   in   N        lane valid mask
//   offset  out  N x OW   slot of each lane relative to the first free slot
//   total   out  OW       number of valid lanes
module free_list_compact #(
  parameter int N = 2,
  localparam int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]    valid,
  output logic [N*OW-1:0] offset,
  output logic [OW-1:0]   total
);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [OW-1:0] acc;
    always_comb begin
      acc = '0;
      for (int j = gi + 1; j < N; j++) begin
        acc = acc + OW'(valid[j]);
      end
    end
    assign offset[gi*OW +: OW] = acc;
  end

  always_comb begin
    total = '0;
    for (int j = 0; j < N; j++) begin
      total = total + OW'(valid[j]);
    end
  end

endmodule

// File: rtl/free_list.sv
// free_list: physical-register free list for the rename path.
// A circular FIFO of free tags: dispatch pops up to N tags per cycle, retire
// pushes up to N Told tags per cycle. On branch recovery the list is emptied
// and rebuilt by scanning a snapshot of the precise arch map, pushing every
// physical tag the map does not reference, N tags per cycle in ascending order.
//   clock, reset    clock and asynchronous active-high reset
//   alloc_req       per-lane allocation request (lane N-1 oldest)
//   alloc_reg       tag granted per lane, 0 for lanes not granted
//   alloc_stall     requests not honoured this cycle
//   free_count      entries currently in the list
//   FL_RetireEN     per-lane return enable
//   FL_RetireReg    per-lane returned tag
//   BPRecoverEN     recovery pulse, dominates everything
//   archi_maptable  precise arch map image, PRW bits per arch register
//   rebuild_busy    rebuild scan in progress
module free_list
  import free_list_pkg::*;
#(
  parameter int N          = FL_N,
  parameter int ARCH_COUNT = FL_ARCH_COUNT,
  parameter int PHYS_REGS  = FL_PHYS_REGS,
  localparam int PRW   = $clog2(PHYS_REGS),
  localparam int DEPTH = PHYS_REGS - ARCH_COUNT,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0]              alloc_req,
  output logic [N*PRW-1:0]          alloc_reg,
  output logic                      alloc_stall,
  output logic [CW-1:0]             free_count,
  input  logic [N-1:0]              FL_RetireEN,
  input  logic [N*PRW-1:0]          FL_RetireReg,
  input  logic                      BPRecoverEN,
  input  logic [ARCH_COUNT*PRW-1:0] archi_maptable,
  output logic                      rebuild_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(N + 1);
  localparam int SW = PRW + 1;  // scan pointer may step past the last tag

  logic [PRW-1:0]       entries_reg [DEPTH];
  logic [PW-1:0]        head_reg;
  logic [PW-1:0]        tail_reg;
  logic [CW-1:0]        count_reg;
  logic [PHYS_REGS-1:0] in_use_reg;
  logic [SW-1:0]        scan_ptr_reg;
  fl_state_e            state_reg;

  // Pointer advance modulo DEPTH; offsets never exceed N <= DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [OW-1:0] d);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(d);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // ---------------- allocation ----------------
  logic [N*OW-1:0] alloc_off;
  logic [OW-1:0]   alloc_k;
  logic [OW-1:0]   alloc_pop;
  logic            alloc_ok;

  free_list_compact #(.N(N)) u_alloc_compact (
    .valid  (alloc_req),
    .offset (alloc_off),
    .total  (alloc_k)
  );

  // All-or-nothing: either every requesting lane gets a tag or none does.
  assign alloc_ok    = (state_reg == IDLE) && !BPRecoverEN && (int'(alloc_k) <= int'(count_reg));
  assign alloc_stall = !alloc_ok;
  assign alloc_pop   = alloc_ok ? alloc_k : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_alloc
    assign alloc_reg[gi*PRW +: PRW] = (alloc_ok && alloc_req[gi])
                                    ? entries_reg[ptr_add(head_reg, alloc_off[gi*OW +: OW])]
                                    : '0;
  end

  // ---------------- rebuild scan lanes ----------------
  // Lane N-1 looks at the lowest tag so the oldest-first packing yields
  // ascending tag order in the list.
  logic [N-1:0]     scan_valid;
  logic [N*PRW-1:0] scan_tag;

  for (genvar gi = 0; gi < N; gi++) begin : g_scan
    logic [SW-1:0] t;
    assign t = scan_ptr_reg + SW'(N - 1 - gi);
    assign scan_valid[gi]           = (t < SW'(PHYS_REGS)) && !in_use_reg[t[PRW-1:0]];
    assign scan_tag[gi*PRW +: PRW]  = t[PRW-1:0];
  end

  // ---------------- push path (returns or rebuild) ----------------
  logic [N-1:0]     push_valid;
  logic [N*PRW-1:0] push_tag;
  logic [N*OW-1:0]  push_off;
  logic [OW-1:0]    push_n;
  logic             push_ok;

  always_comb begin
    push_valid = '0;
    push_tag   = FL_RetireReg;
    if (BPRecoverEN) begin
      push_valid = '0;
    end else if (state_reg == REBUILD) begin
      push_valid = scan_valid;
      push_tag   = scan_tag;
    end else begin
      push_valid = FL_RetireEN;
    end
  end

  free_list_compact #(.N(N)) u_push_compact (
    .valid  (push_valid),
    .offset (push_off),
    .total  (push_n)
  );

  // A push group that would overfill the list is dropped whole.
  assign push_ok = (int'(count_reg) - int'(alloc_pop) + int'(push_n)) <= DEPTH;

  // Snapshot of tags referenced by the arch map.
  logic [PHYS_REGS-1:0] map_mask;
  always_comb begin
    map_mask = '0;
    for (int a = 0; a < ARCH_COUNT; a++) begin
      map_mask[archi_maptable[a*PRW +: PRW]] = 1'b1;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= PRW'(ARCH_COUNT + i);
      end
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= CW'(DEPTH);
      in_use_reg   <= '0;
      scan_ptr_reg <= '0;
      state_reg    <= IDLE;
    end else if (BPRecoverEN) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      in_use_reg   <= map_mask;
      scan_ptr_reg <= '0;
      state_reg    <= REBUILD;
    end else begin
      if (push_ok) begin
        for (int i = 0; i < N; i++) begin
          if (push_valid[i]) begin
            entries_reg[ptr_add(tail_reg, push_off[i*OW +: OW])] <= push_tag[i*PRW +: PRW];
          end
        end
        tail_reg <= ptr_add(tail_reg, push_n);
      end
      head_reg  <= ptr_add(head_reg, alloc_pop);
      count_reg <= CW'(int'(count_reg) - int'(alloc_pop) + (push_ok ? int'(push_n) : 0));
      if (state_reg == REBUILD) begin
        scan_ptr_reg <= scan_ptr_reg + SW'(N);
        if (int'(scan_ptr_reg) + N >= PHYS_REGS) state_reg <= IDLE;
      end
    end
  end

  assign free_count   = count_reg;
  assign rebuild_busy = (state_reg == REBUILD);

  // Protocol checks: the ROB is flushed during a rebuild, tag 0 is never free,
  // and the list can never hold more than DEPTH tags.
  always @(posedge clock) begin
    if (!reset && !BPRecoverEN) begin
      if (state_reg == REBUILD) begin
        assert (FL_RetireEN == '0) else $error("free_list: return during rebuild");
      end
      assert (push_ok) else $error("free_list: push overflows list");
      for (int i = 0; i < N; i++) begin
        if (push_valid[i]) begin
          assert (push_tag[i*PRW +: PRW] != '0) else $error("free_list: push of tag 0");
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed bench for free_list (N=2, 64 physical, 32 arch).
// Inputs change just after the falling edge; outputs are checked a few ns
// later, well before the next rising edge.
module tb_free_list;

  localparam int N    = 2;
  localparam int ARCH = 32;
  localparam int PRW  = 6;
  localparam int CW   = 6;

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       alloc_req;
  logic [N*PRW-1:0]   alloc_reg;
  logic               alloc_stall;
  logic [CW-1:0]      free_count;
  logic [N-1:0]       FL_RetireEN;
  logic [N*PRW-1:0]   FL_RetireReg;
  logic               BPRecoverEN;
  logic [ARCH*PRW-1:0] archi_maptable;
  logic               rebuild_busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  free_list dut (
    .clock          (clock),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_reg      (alloc_reg),
    .alloc_stall    (alloc_stall),
    .free_count     (free_count),
    .FL_RetireEN    (FL_RetireEN),
    .FL_RetireReg   (FL_RetireReg),
    .BPRecoverEN    (BPRecoverEN),
    .archi_maptable (archi_maptable),
    .rebuild_busy   (rebuild_busy)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [PRW-1:0] lane(input logic [N*PRW-1:0] v, input int i);
    return v[i*PRW +: PRW];
  endfunction

  task automatic next();
    @(negedge clock);
    #1;
  endtask

  // Map A: r0->P0, ri->P(32+i); free tags are P1..P32.
  task automatic set_map_a();
    for (int r = 0; r < ARCH; r++) begin
      archi_maptable[r*PRW +: PRW] = (r == 0) ? PRW'(0) : PRW'(32 + r);
    end
  endtask

  // Map B: identity; free tags are P32..P63.
  task automatic set_map_b();
    for (int r = 0; r < ARCH; r++) begin
      archi_maptable[r*PRW +: PRW] = PRW'(r);
    end
  endtask

  task automatic wait_rebuild(input string tag, input int expected_cycles);
    int cycles = 0;
    while (rebuild_busy === 1'b1 && cycles < 100) begin
      cycles++;
      next();
    end
    check(tag, cycles, expected_cycles);
  endtask

  task automatic drain_pairs(input string tag, input int first_tag);
    for (int c = 0; c < 16; c++) begin
      alloc_req = 2'b11;
      #1;
      check($sformatf("%s_l1_%0d", tag, c), lane(alloc_reg, 1), first_tag + 2*c);
      check($sformatf("%s_l0_%0d", tag, c), lane(alloc_reg, 0), first_tag + 2*c + 1);
      next();
    end
    alloc_req = 2'b00;
    #1;
    check({tag, "_empty"}, free_count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; alloc_req = '0; FL_RetireEN = '0; FL_RetireReg = '0; BPRecoverEN = 1'b0;
    set_map_a();
    repeat (2) @(negedge clock);
    #1; reset = 1'b0; #1;

    // Reset image
    check("reset_count", free_count, 32);
    check("reset_busy", rebuild_busy, 0);
    check("reset_stall", alloc_stall, 0);
    check("reset_alloc_reg", alloc_reg, 0);

    // First allocation: oldest lane gets the head
    alloc_req = 2'b11; #1;
    check("alloc0_l1", lane(alloc_reg, 1), 32);
    check("alloc0_l0", lane(alloc_reg, 0), 33);
    next(); alloc_req = 2'b00; #1;
    check("alloc0_count", free_count, 30);

    // Drain down to two entries (head 2 -> 30)
    for (int c = 0; c < 14; c++) begin
      alloc_req = 2'b11; #1;
      check($sformatf("drain_l1_%0d", c), lane(alloc_reg, 1), 34 + 2*c);
      check($sformatf("drain_l0_%0d", c), lane(alloc_reg, 0), 35 + 2*c);
      next();
    end
    alloc_req = 2'b10; #1;
    check("single_l1", lane(alloc_reg, 1), 62);
    next(); alloc_req = 2'b00; #1;
    check("count_one", free_count, 1);

    // Two requests with one entry: all-or-nothing stall
    alloc_req = 2'b11; #1;
    check("stall_k_gt_count", alloc_stall, 1);
    check("stall_no_grant", alloc_reg, 0);
    next(); alloc_req = 2'b00; #1;
    check("stall_count_kept", free_count, 1);

    // Return one tag to slot 0, then allocate a pair straddling the wrap
    FL_RetireEN = 2'b01; FL_RetireReg = {6'd0, 6'd45};
    next(); FL_RetireEN = '0; #1;
    check("ret45_count", free_count, 2);
    alloc_req = 2'b11; #1;
    check("wrap_l1", lane(alloc_reg, 1), 63);
    check("wrap_l0", lane(alloc_reg, 0), 45);
    next(); alloc_req = 2'b00; #1;
    check("wrap_count", free_count, 0);

    // Return while empty: no same-cycle bypass
    alloc_req = 2'b10; FL_RetireEN = 2'b11; FL_RetireReg = {6'd50, 6'd51}; #1;
    check("nobypass_stall", alloc_stall, 1);
    check("nobypass_reg", lane(alloc_reg, 1), 0);
    next(); alloc_req = 2'b00;
    FL_RetireEN = 2'b11; FL_RetireReg = {6'd52, 6'd53};
    next();
    FL_RetireEN = 2'b10; FL_RetireReg = {6'd54, 6'd0};
    next(); FL_RetireEN = '0; #1;
    check("five_count", free_count, 5);

    // Simultaneous pop 2 / push 2
    alloc_req = 2'b11; FL_RetireEN = 2'b11; FL_RetireReg = {6'd40, 6'd41}; #1;
    check("pushpop_l1", lane(alloc_reg, 1), 50);
    check("pushpop_l0", lane(alloc_reg, 0), 51);
    next(); alloc_req = 2'b00; FL_RetireEN = '0; #1;
    check("pushpop_count", free_count, 5);
    alloc_req = 2'b11; #1;
    check("fifo_a_l1", lane(alloc_reg, 1), 52);
    check("fifo_a_l0", lane(alloc_reg, 0), 53);
    next(); #1;
    check("fifo_b_l1", lane(alloc_reg, 1), 54);
    check("fifo_b_l0", lane(alloc_reg, 0), 40);
    next(); alloc_req = 2'b10; #1;
    check("fifo_c_l1", lane(alloc_reg, 1), 41);
    check("fifo_c_stall", alloc_stall, 0);
    next(); alloc_req = 2'b00; #1;
    check("fifo_empty", free_count, 0);

    // Recovery with map A; returns and requests in that cycle are ignored
    set_map_a();
    BPRecoverEN = 1'b1; alloc_req = 2'b11; FL_RetireEN = 2'b11; FL_RetireReg = {6'd7, 6'd8}; #1;
    check("recov_stall", alloc_stall, 1);
    check("recov_no_grant", alloc_reg, 0);
    next(); BPRecoverEN = 1'b0; FL_RetireEN = '0; #1;
    check("rebuild_busy_on", rebuild_busy, 1);
    check("rebuild_stall", alloc_stall, 1);
    check("rebuild_count0", free_count, 0);
    wait_rebuild("rebuild_a_cycles", 32);
    alloc_req = 2'b00; #1;
    check("rebuild_a_count", free_count, 32);
    check("rebuild_a_busy_off", rebuild_busy, 0);
    drain_pairs("list_a", 1);

    // Recovery restarted at rebuild cycle 10 with map B; live map changed after
    BPRecoverEN = 1'b1;
    next(); BPRecoverEN = 1'b0;
    repeat (9) next();
    set_map_b(); BPRecoverEN = 1'b1;
    next(); BPRecoverEN = 1'b0; set_map_a(); #1;
    check("restart_count0", free_count, 0);
    wait_rebuild("rebuild_b_cycles", 32);
    check("rebuild_b_count", free_count, 32);
    drain_pairs("list_b", 32);

    // Reset in the middle of a rebuild
    BPRecoverEN = 1'b1;
    next(); BPRecoverEN = 1'b0;
    repeat (4) next();
    check("midreb_busy", rebuild_busy, 1);
    reset = 1'b1; #1;
    check("midreb_reset_count", free_count, 32);
    check("midreb_reset_busy", rebuild_busy, 0);
    next(); reset = 1'b0; alloc_req = 2'b11; #1;
    check("post_reset_l1", lane(alloc_reg, 1), 32);
    check("post_reset_l0", lane(alloc_reg, 0), 33);
    check("post_reset_stall", alloc_stall, 0);
    next(); alloc_req = 2'b00; #1;
    check("post_reset_count", free_count, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
